data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the core's data-memory interface: accepts the byte-enable/write-enable/signedness requests the instruction decoder produces, and services them from an on-chip word-organised scratchpad. Stores are lane-steered from the low bits of the store data. Loads are returned right-aligned and sign- or zero-extended. A one-deep response register with valid/ready handshaking lets the core's load/store stage stall uniformly on both loads and stores.

## Interface
- ADDR_WIDTH, default 10: word-address width; scratchpad depth is 2^ADDR_WIDTH 32-bit words.
- clk  input  1  rising-edge clock.
- resetb  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request can be accepted this cycle.
- req_addr  input  32  byte address; bits [1:0] ignored, lanes come from req_be.
- req_we  input  1  1 = store, 0 = load.
- req_be  input  4  byte enables (decoder dm_be encoding).
- req_is_signed  input  1  load extension: 1 = sign, 0 = zero.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  response available.
- resp_ready  input  1  core accepts response.
- resp_rdata  output  32  load result (0 for stores and faults).
- resp_fault  output  1  access fault for this response.

## Operation
- Handshake: request accepted on a rising edge with req_valid && req_ready. req_ready = !resp_valid || resp_ready (combinational), giving full back-to-back throughput.
- Legal req_be: 0001, 0010, 0100, 1000 (byte); 0011, 1100 (half); 1111 (word). Any other value, including 0000, is illegal.
- Fault on acceptance when:
  - req_be is illegal, or
  - req_addr[31:2] >= 2^ADDR_WIDTH.
- A faulting request does not access memory. Its response has resp_fault=1 and resp_rdata=0.
- Store (legal):
  - Byte: replicate req_wdata[7:0] to all lanes.
  - Half: replicate req_wdata[15:0] to both halves.
  - Write only the enabled lanes of word req_addr[ADDR_WIDTH+1:2] at the acceptance edge.
  - Response: resp_rdata=0, resp_fault=0.
- Load (legal): read the word, then select by req_be:
  - Byte: take the enabled lane, extend bit 7 per req_is_signed.
  - Half: take the enabled half, extend bit 15 per req_is_signed.
  - Word: pass through unchanged; req_is_signed is ignored.
- Response register states:
  - EMPTY (resp_valid=0).
  - FULL (resp_valid=1).
- Transitions:
  - EMPTY→FULL on accept.
  - FULL→FULL on accept && resp_ready; the new response replaces the old one.
  - FULL→EMPTY on resp_ready && !accept.
  - FULL with !resp_ready: hold; resp_rdata and resp_fault stay stable.
- Load/extend/sign control must be captured with the request so the held response does not depend on current inputs.
- Memory contents are not initialised or reset.

## Timing
- Reset (resetb low, asynchronous): resp_valid=0, resp_fault=0, resp_rdata=0, state EMPTY. req_ready=1 once resetb is high.
- Latency: request accepted at edge N gives resp_valid=1 and valid data after edge N, i.e. in cycle N+1.
- Read-after-write to the same word in consecutive accepted requests returns the newly written data; there is no stale read.
- Simultaneous retire and accept in FULL: the old response retires and the new one is presented in the next cycle, so resp_valid stays high.
- Reset asserted mid-transaction:
  - The pending response is dropped.
  - A store accepted on the same edge as reset assertion may or may not commit.
  - No response is ever presented after reset.
- Stores commit at the acceptance edge, independent of when the response is consumed.

## Test plan
- Reset: hold resetb=0 with random inputs → resp_valid=0, resp_rdata=0, resp_fault=0. After release, req_ready=1.
- Word store/load at 0x0000_0010:
  - Store 0xDEADBEEF with be=1111.
  - Load with be=1111 → resp_rdata=0xDEADBEEF, one cycle after acceptance.
- Byte/half extension at the same word:
  - Byte, be=0100, signed → 0xFFFFFFAD.
  - Byte, be=0100, unsigned → 0x000000AD.
  - Half, be=1100, signed → 0xFFFFDEAD.
  - Half, be=0011, unsigned → 0x0000BEEF.
- Lane stores:
  - Store wdata=0x00000055 with be=0010 to word 0x10 → a word load returns 0xDEAD55EF.
  - Store wdata=0x00001234 with be=1100 → a word load returns 0x123455EF.
- Backpressure:
  - Issue two loads back-to-back with resp_ready=0 → second request stalled (req_ready=0). First response held stable for 5 cycles.
  - Then resp_ready=1 → both responses are delivered in order on consecutive cycles.
- Faults, with ADDR_WIDTH=10:
  - Load at 0x0000_1000 → resp_fault=1, resp_rdata=0.
  - be=0110 → resp_fault=1, memory unchanged.
  - be=0000 store → fault, and a subsequent word load shows the original data.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: word-organised scratchpad behind a one-deep
// valid/ready response register, with lane-steered stores and extended loads.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic        req_is_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } resp_state_e;

  resp_state_e           state_q;
  logic [31:0]           resp_rdata_q;
  logic                  resp_fault_q;
  logic [31:0]           resp_rdata_d;

  logic [31:0]           mem_q [DEPTH];

  logic [29:0]           word_addr;
  logic [ADDR_WIDTH-1:0] mem_idx;
  logic                  addr_oob;
  logic                  be_legal;
  logic                  fault_c;
  logic                  accept_c;
  logic [31:0]           rd_word;
  logic [31:0]           wdata_rep;
  logic [31:0]           load_data;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic                  unused_addr_bits;

  // Low address bits carry no meaning; lanes come from req_be.
  assign unused_addr_bits = ^req_addr[1:0];

  assign word_addr  = req_addr[31:2];
  assign mem_idx    = req_addr[ADDR_WIDTH+1:2];
  assign addr_oob   = (word_addr >> ADDR_WIDTH) != 30'd0;

  assign resp_valid = (state_q == FULL);
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;
  assign req_ready  = !resp_valid || resp_ready;
  assign accept_c   = req_valid && req_ready;

  // Byte-enable legality: single byte, aligned half, or full word.
  always_comb begin
    be_legal = 1'b0;
    case (req_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: be_legal = 1'b1;
      4'b0011, 4'b1100:                   be_legal = 1'b1;
      4'b1111:                            be_legal = 1'b1;
      default:                            be_legal = 1'b0;
    endcase
  end

  assign fault_c = !be_legal || addr_oob;

  // Replicate right-aligned store data so every enabled lane sees it.
  always_comb begin
    wdata_rep = req_wdata;
    case (req_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: wdata_rep = {4{req_wdata[7:0]}};
      4'b0011, 4'b1100:                   wdata_rep = {2{req_wdata[15:0]}};
      default:                            wdata_rep = req_wdata;
    endcase
  end

  // Scratchpad write port: enabled lanes commit at the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept_c && req_we && !fault_c) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) begin
          mem_q[mem_idx][i*8 +: 8] <= wdata_rep[i*8 +: 8];
        end
      end
    end
  end

  assign rd_word = mem_q[mem_idx];

  // Load lane select and extension, resolved at acceptance time.
  always_comb begin
    lane_byte = rd_word[7:0];
    lane_half = rd_word[15:0];
    load_data = rd_word;
    case (req_be)
      4'b0010: lane_byte = rd_word[15:8];
      4'b0100: lane_byte = rd_word[23:16];
      4'b1000: lane_byte = rd_word[31:24];
      default: lane_byte = rd_word[7:0];
    endcase
    if (req_be == 4'b1100) begin
      lane_half = rd_word[31:16];
    end
    case (req_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000:
        load_data = {{24{req_is_signed & lane_byte[7]}}, lane_byte};
      4'b0011, 4'b1100:
        load_data = {{16{req_is_signed & lane_half[15]}}, lane_half};
      default:
        load_data = rd_word;
    endcase
  end

  // Stores and faults return zero data.
  assign resp_rdata_d = (fault_c || req_we) ? 32'd0 : load_data;

  // Response register: capture on accept, retire on resp_ready, else hold.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q      <= EMPTY;
      resp_rdata_q <= 32'd0;
      resp_fault_q <= 1'b0;
    end else begin
      if (accept_c) begin
        state_q      <= FULL;
        resp_rdata_q <= resp_rdata_d;
        resp_fault_q <= fault_c;
      end else if (resp_ready) begin
        state_q      <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
module tb_data_mem_responder;

  logic        clk;
  logic        resetb;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_be;
  logic        req_is_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  int tests_run;
  int tests_failed;

  data_mem_responder #(.ADDR_WIDTH(10)) dut (
    .clk           (clk),
    .resetb        (resetb),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_we        (req_we),
    .req_be        (req_be),
    .req_is_signed (req_is_signed),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_fault    (resp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request at the falling edge; it is accepted at the next rising edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic sgn, input logic [31:0] wdata, input string tag);
    @(negedge clk);
    req_valid     = 1'b1;
    req_we        = we;
    req_addr      = addr;
    req_be        = be;
    req_is_signed = sgn;
    req_wdata     = wdata;
    check(32'(req_ready), 32'd1, {tag, "_ready"});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Check the response one cycle after acceptance.
  task automatic expect_resp(input logic [31:0] rdata, input logic fault, input string tag);
    @(negedge clk);
    check(32'(resp_valid), 32'd1, {tag, "_valid"});
    check(resp_rdata, rdata, {tag, "_rdata"});
    check(32'(resp_fault), 32'(fault), {tag, "_fault"});
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    resetb        = 1'b0;
    req_valid     = 1'b0;
    req_addr      = 32'd0;
    req_we        = 1'b0;
    req_be        = 4'd0;
    req_is_signed = 1'b0;
    req_wdata     = 32'd0;
    resp_ready    = 1'b1;

    // Reset with random inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid     = 1'($urandom);
      req_addr      = $urandom & 32'h0000_0FFC;
      req_we        = 1'($urandom);
      req_be        = 4'($urandom);
      req_is_signed = 1'($urandom);
      req_wdata     = $urandom;
      resp_ready    = 1'($urandom);
    end
    @(negedge clk);
    check(32'(resp_valid), 32'd0, "rst_valid");
    check(resp_rdata, 32'd0, "rst_rdata");
    check(32'(resp_fault), 32'd0, "rst_fault");
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    resetb     = 1'b1;
    @(negedge clk);
    check(32'(req_ready), 32'd1, "rst_req_ready");
    check(32'(resp_valid), 32'd0, "rst_idle_valid");

    // Word store and load.
    issue(1'b1, 32'h0000_0010, 4'b1111, 1'b0, 32'hDEAD_BEEF, "st_word");
    expect_resp(32'd0, 1'b0, "st_word");
    issue(1'b0, 32'h0000_0010, 4'b1111, 1'b0, 32'd0, "ld_word");
    expect_resp(32'hDEAD_BEEF, 1'b0, "ld_word");

    // Byte and half extension.
    issue(1'b0, 32'h0000_0010, 4'b0100, 1'b1, 32'd0, "ld_b2_s");
    expect_resp(32'hFFFF_FFAD, 1'b0, "ld_b2_s");
    issue(1'b0, 32'h0000_0010, 4'b0100, 1'b0, 32'd0, "ld_b2_u");
    expect_resp(32'h0000_00AD, 1'b0, "ld_b2_u");
    issue(1'b0, 32'h0000_0010, 4'b1100, 1'b1, 32'd0, "ld_hhi_s");
    expect_resp(32'hFFFF_DEAD, 1'b0, "ld_hhi_s");
    issue(1'b0, 32'h0000_0010, 4'b0011, 1'b0, 32'd0, "ld_hlo_u");
    expect_resp(32'h0000_BEEF, 1'b0, "ld_hlo_u");
    issue(1'b0, 32'h0000_0010, 4'b0011, 1'b1, 32'd0, "ld_hlo_s");
    expect_resp(32'hFFFF_BEEF, 1'b0, "ld_hlo_s");
    issue(1'b0, 32'h0000_0010, 4'b1000, 1'b1, 32'd0, "ld_b3_s");
    expect_resp(32'hFFFF_FFDE, 1'b0, "ld_b3_s");

    // Lane stores.
    issue(1'b1, 32'h0000_0010, 4'b0010, 1'b0, 32'h0000_0055, "st_b1");
    expect_resp(32'd0, 1'b0, "st_b1");
    issue(1'b0, 32'h0000_0010, 4'b1111, 1'b0, 32'd0, "ld_after_b1");
    expect_resp(32'hDEAD_55EF, 1'b0, "ld_after_b1");
    issue(1'b1, 32'h0000_0010, 4'b1100, 1'b0, 32'h0000_1234, "st_hhi");
    expect_resp(32'd0, 1'b0, "st_hhi");
    issue(1'b0, 32'h0000_0010, 4'b1111, 1'b0, 32'd0, "ld_after_hhi");
    expect_resp(32'h1234_55EF, 1'b0, "ld_after_hhi");

    // Back-to-back store then load to a new word: no stale read.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0020;
    req_be = 4'b1111; req_is_signed = 1'b0; req_wdata = 32'hA5A5_0F0F;
    @(posedge clk);
    #1;
    req_we = 1'b0; req_be = 4'b0001; req_is_signed = 1'b0; req_wdata = 32'd0;
    @(negedge clk);
    check(32'(resp_valid), 32'd1, "raw_st_valid");
    check(32'(req_ready), 32'd1, "raw_ld_ready");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check(32'(resp_valid), 32'd1, "raw_ld_valid");
    check(resp_rdata, 32'h0000_000F, "raw_ld_rdata");

    // Backpressure: second load stalls while the first is held.
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0010;
    req_be = 4'b1111; req_is_signed = 1'b0;
    @(posedge clk);
    #1;
    req_be = 4'b0001; req_is_signed = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_wdata = $urandom;
      check(32'(resp_valid), 32'd1, "bp_hold_valid");
      check(resp_rdata, 32'h1234_55EF, "bp_hold_rdata");
      check(32'(req_ready), 32'd0, "bp_stall_ready");
    end
    resp_ready = 1'b1;
    #1;
    check(32'(req_ready), 32'd1, "bp_release_ready");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check(32'(resp_valid), 32'd1, "bp_second_valid");
    check(resp_rdata, 32'hFFFF_FFEF, "bp_second_rdata");
    @(negedge clk);
    check(32'(resp_valid), 32'd0, "bp_drained");

    // Faults.
    issue(1'b0, 32'h0000_1000, 4'b1111, 1'b0, 32'd0, "flt_oob");
    expect_resp(32'd0, 1'b1, "flt_oob");
    issue(1'b1, 32'h0000_0010, 4'b0110, 1'b0, 32'hFFFF_FFFF, "flt_be0110");
    expect_resp(32'd0, 1'b1, "flt_be0110");
    issue(1'b0, 32'h0000_0010, 4'b1111, 1'b0, 32'd0, "ld_after_0110");
    expect_resp(32'h1234_55EF, 1'b0, "ld_after_0110");
    issue(1'b1, 32'h0000_0010, 4'b0000, 1'b0, 32'hFFFF_FFFF, "flt_be0000");
    expect_resp(32'd0, 1'b1, "flt_be0000");
    issue(1'b0, 32'h0000_0010, 4'b1111, 1'b0, 32'd0, "ld_after_0000");
    expect_resp(32'h1234_55EF, 1'b0, "ld_after_0000");
    issue(1'b1, 32'h0000_0FFC, 4'b1111, 1'b0, 32'h0BAD_F00D, "st_top");
    expect_resp(32'd0, 1'b0, "st_top");
    issue(1'b0, 32'h0000_0FFC, 4'b1111, 1'b0, 32'd0, "ld_top");
    expect_resp(32'h0BAD_F00D, 1'b0, "ld_top");

    // Reset mid-transaction drops the held response.
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0010; req_be = 4'b1111;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check(32'(resp_valid), 32'd1, "mid_rst_pending");
    #2;
    resetb = 1'b0;
    #1;
    check(32'(resp_valid), 32'd0, "mid_rst_valid");
    check(resp_rdata, 32'd0, "mid_rst_rdata");
    @(negedge clk);
    resetb = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check(32'(resp_valid), 32'd0, "post_rst_valid");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
